class_link_scheduler: RTL and testbench

- Shares one physical AXI-Stream output link between two traffic classes: request (REQ) and response (RESP).
- Sits between the per-class router outputs and a single-lane inter-router link, or a link serializer.
- Packet-granular: once a packet starts, its grant is held until TLAST.
- RESP has priority (protocol-deadlock avoidance); a streak limiter guarantees REQ forward progress.
- Per-class packet counters feed the PMUs.

---
 rtl/class_link_scheduler_pkg.sv | 15 +
 rtl/class_link_scheduler_pkt_counter.sv | 13 +
 rtl/class_link_scheduler.sv | 55 +++++
 tb/tb_class_link_scheduler.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/class_link_scheduler_pkg.sv
// class_link_scheduler_pkg: stream types, class encoding and scheduler states
package class_link_scheduler_pkg;
  localparam int AXIS_DATA_WIDTH = 32;
  localparam logic CLS_REQ = 1'b0;
  localparam logic CLS_RESP = 1'b1;
  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic                       tlast;
    logic                       tvalid;
  } axis_mosi_t;
  typedef struct packed {
    logic tready;
  } axis_miso_t;
  typedef enum logic [1:0] {IDLE, LOCK_REQ, LOCK_RESP} sched_state_t;
endpackage

// File: rtl/class_link_scheduler_pkt_counter.sv
// class_pkt_counter: wrapping packet counter advanced by a one-cycle strobe
module class_pkt_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_o <= '0;
    else if (inc_i) cnt_o <= cnt_o + 1'b1;
endmodule

// File: rtl/class_link_scheduler.sv
// class_link_scheduler: packet-granular RESP-priority mux of two stream classes onto one link
module class_link_scheduler
  import class_link_scheduler_pkg::*;
#(
  parameter int MAX_RESP_STREAK = 4,
  parameter int STREAK_WIDTH    = $clog2(MAX_RESP_STREAK + 1),
  parameter int CNT_WIDTH       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  axis_mosi_t           req_mosi_i,
  output axis_miso_t           req_miso_o,
  input  axis_mosi_t           resp_mosi_i,
  output axis_miso_t           resp_miso_o,
  output axis_mosi_t           out_mosi_o,
  input  axis_miso_t           out_miso_i,
  output logic                 out_class_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt_req_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt_resp_o
);
  localparam logic [STREAK_WIDTH-1:0] SMAX = STREAK_WIDTH'(MAX_RESP_STREAK);
  sched_state_t state_q, state_d;
  logic [STREAK_WIDTH-1:0] streak_q, streak_d;
  logic resp_win, sel_cls, active, xfer, done;
  axis_mosi_t sel;
  always_comb begin
    resp_win = resp_mosi_i.tvalid && (streak_q < SMAX || !req_mosi_i.tvalid);
    sel_cls = state_q == LOCK_RESP || (state_q == IDLE && resp_win);
    active = rst_n_i && (state_q != IDLE || req_mosi_i.tvalid || resp_mosi_i.tvalid);
    sel = sel_cls ? resp_mosi_i : req_mosi_i;
    out_mosi_o = active ? sel : '0;
    out_class_o = sel_cls;
    req_miso_o.tready = active && sel_cls == CLS_REQ && out_miso_i.tready;
    resp_miso_o.tready = active && sel_cls == CLS_RESP && out_miso_i.tready;
    xfer = out_mosi_o.tvalid && out_miso_i.tready;
    done = xfer && out_mosi_o.tlast;
    state_d = !xfer ? state_q : out_mosi_o.tlast ? IDLE : sel_cls ? LOCK_RESP : LOCK_REQ;
    streak_d = !done ? streak_q :
               (sel_cls == CLS_RESP && req_mosi_i.tvalid) ? (streak_q == SMAX ? SMAX : streak_q + 1'b1) : '0;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      streak_q <= '0;
    end else begin
      state_q <= state_d;
      streak_q <= streak_d;
    end
  class_pkt_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_req (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .inc_i(done && sel_cls == CLS_REQ), .cnt_o(pkt_cnt_req_o)
  );
  class_pkt_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_resp (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .inc_i(done && sel_cls == CLS_RESP), .cnt_o(pkt_cnt_resp_o)
  );
endmodule

// File: tb/tb_class_link_scheduler.sv
// tb_class_link_scheduler: random and directed checks against a packet-level reference model
module tb_class_link_scheduler;
  import class_link_scheduler_pkg::*;
  localparam int MAX = 4;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  axis_mosi_t req = '0, resp = '0, out;
  axis_miso_t req_m, resp_m, out_m = '0;
  logic out_cls;
  logic [CW-1:0] c_req, c_resp;
  int vectors = 0, miscompares = 0;
  int m_owner = -1, m_streak = 0, m_creq = 0, m_cresp = 0;
  int exp1 [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  int f = -1;
  always #5 clk = ~clk;
  class_link_scheduler #(.MAX_RESP_STREAK(MAX), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_mosi_i(req), .req_miso_o(req_m),
    .resp_mosi_i(resp), .resp_miso_o(resp_m),
    .out_mosi_o(out), .out_miso_i(out_m), .out_class_o(out_cls),
    .pkt_cnt_req_o(c_req), .pkt_cnt_resp_o(c_resp)
  );
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic axis_mosi_t mk(logic v, logic l, logic [31:0] d);
    mk.tvalid = v;
    mk.tlast = l;
    mk.tdata = d;
  endfunction
  function automatic axis_mosi_t nb(int p);
    return mk($urandom_range(0, 99) < p, $urandom_range(0, 2) == 0, $urandom);
  endfunction
  task automatic drv(axis_mosi_t rq, axis_mosi_t rs, logic rdy);
    @(posedge clk);
    #1;
    req = rq;
    resp = rs;
    out_m.tready = rdy;
  endtask
  task automatic eval(output int fired);
    int g;
    logic ev, lst;
    @(negedge clk);
    g = m_owner >= 0 ? m_owner :
        (resp.tvalid && (m_streak < MAX || !req.tvalid)) ? 1 : req.tvalid ? 0 : -1;
    ev = g == 1 ? resp.tvalid : g == 0 ? req.tvalid : 1'b0;
    chk("out_tvalid", out.tvalid, ev);
    if (ev) begin
      chk("out_class", out_cls, g);
      chk("out_tdata", out.tdata, g == 1 ? resp.tdata : req.tdata);
      chk("out_tlast", out.tlast, g == 1 ? resp.tlast : req.tlast);
    end
    if (g < 0) chk("out_idle_zero", out, '0);
    chk("req_tready", req_m.tready, g == 0 && out_m.tready);
    chk("resp_tready", resp_m.tready, g == 1 && out_m.tready);
    chk("cnt_req", c_req, m_creq);
    chk("cnt_resp", c_resp, m_cresp);
    fired = -1;
    if (ev && out_m.tready) begin
      fired = g;
      lst = g == 1 ? resp.tlast : req.tlast;
      m_owner = lst ? -1 : g;
      if (lst && g == 1) begin
        m_cresp = (m_cresp + 1) % (1 << CW);
        m_streak = req.tvalid ? (m_streak + 1 > MAX ? MAX : m_streak + 1) : 0;
      end else if (lst) begin
        m_creq = (m_creq + 1) % (1 << CW);
        m_streak = 0;
      end
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_tvalid", out.tvalid, 1'b0);
    chk("rst_req_tready", req_m.tready, 1'b0);
    chk("rst_resp_tready", resp_m.tready, 1'b0);
    chk("rst_cnt_req", c_req, 0);
    chk("rst_cnt_resp", c_resp, 0);
    req = '0;
    resp = '0;
    m_owner = -1;
    m_streak = 0;
    m_creq = 0;
    m_cresp = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drv(mk(1, 1, 32'h100 + i), mk(1, 1, 32'h200 + i), 1'b1);
      eval(f);
      chk("t1_class_seq", out_cls, exp1[i]);
    end
    drv('0, '0, 1'b1);
    eval(f);
    chk("t1_cnt_resp", c_resp, 8);
    chk("t1_cnt_req", c_req, 2);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drv(mk(1, 1, 32'h300 + i), '0, 1'b1);
      eval(f);
      chk("t4_req_b2b", out.tvalid, 1'b1);
    end
    drv('0, '0, 1'b1);
    eval(f);
    chk("t4_cnt_req", c_req, 5);
    drv(mk(0, 0, 0), mk(1, 1, 32'hA), 1'b1);
    eval(f);
    drv(mk(1, 0, 32'hB1), '0, 1'b1);
    eval(f);
    drv(mk(1, 0, 32'hB2), '0, 1'b1);
    eval(f);
    @(posedge clk);
    #1;
    req = mk(1, 0, 32'hB3);
    do_reset();
    drv('0, mk(1, 1, 32'hC0), 1'b1);
    eval(f);
    chk("t5_resp_after_rst", {out.tvalid, out_cls}, 2'b11);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drv('0, mk(1, 1, i), 1'b1);
      eval(f);
    end
    drv('0, '0, 1'b1);
    eval(f);
    chk("t6_resp_wrap", c_resp, 1);
    f = -1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (f == 0 || !req.tvalid) req = nb(i < 2000 ? 90 : 45);
      if (f == 1 || !resp.tvalid) resp = nb(i < 2000 ? 95 : 50);
      out_m.tready = $urandom_range(0, 3) != 0;
      eval(f);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
